bcd_updown_timer: RTL
=====================

Name: bcd_updown_timer

Overview:
- Parametrised up/down BCD timer core; next-generation replacement for the fixed 0..999 binary stopwatch/countdown logic feeding lcd_top.
- Built-in programmable prescaler with rate multiplier, DIGITS-wide BCD count, preset/limit registers, and an explicit run-control FSM.
- Expiry/warning flags and warn LED blink.
- Outputs BCD digits directly, so no divide/modulo is needed at the display.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency.
- BASE_HZ, 10, tick rate at rate_sel=00.
- DIGITS, 3, number of BCD digits in the count.
- WARN_LEVEL, 50, countdown warning threshold, as a binary value compared against the BCD count.
- BLINK_CYCLES, 25_000_000, clk_50M cycles per warn_led half-period.

Ports:
- clk_50M  in  1  system clock.
- reset_btn  in  1  synchronous active-high reset.
- start_stop  in  1  one-cycle pulse (already debounced); toggles run/pause.
- clear  in  1  one-cycle pulse; reloads count (0 when up, preset when down).
- dir  in  1  0=count up, 1=count down.
- rate_sel  in  2  tick multiplier: 00 x1, 01 x2, 10 x4, 11 x8.
- preset  in  4*DIGITS  BCD countdown start value.
- preset_load  in  1  pulse; latches preset.
- limit  in  4*DIGITS  BCD up-count terminal value.
- bcd_out  out  4*DIGITS  current count, BCD, digit 0 = LSD.
- running  out  1  FSM in RUN.
- done  out  1  one-cycle pulse when countdown reaches 0.
- expired  out  1  level; FSM in EXPIRED.
- wrap  out  1  one-cycle pulse on up-count wrap limit->0.
- warn_led  out  1  blinks while dir=1, RUN, count <= WARN_LEVEL.
- tick  out  1  one-cycle prescaler pulse (debug/probe).

Behaviour:
- Reset: bcd_out=0, preset_q=0, FSM=IDLE, prescaler=0, dir_q=0, all outputs 0.
- Prescaler terminal count is CLK_HZ/(BASE_HZ<<rate_sel)-1. tick pulses when the prescaler hits terminal count.
- A change of rate_sel zeroes the prescaler on the same cycle.
- The prescaler runs only in RUN; it is zeroed in every other state.
- dir_q copies dir only outside RUN; dir changes during RUN are ignored until the next pause.
- preset_load is accepted outside RUN only. Each digit >9 is clamped to 9.
- FSM states and transitions:
  - IDLE: start_stop goes to RUN. If dir_q=1 and count=0, start_stop is ignored.
  - RUN: start_stop goes to PAUSE.
  - RUN, down tick with count=1: go to EXPIRED. On the same cycle count becomes 0 and done=1.
  - PAUSE: start_stop goes to RUN. clear goes to IDLE.
  - EXPIRED: clear or start_stop goes to IDLE with count = preset_q.
- Count arithmetic is per-digit BCD with carry/borrow ripple, completed in the tick cycle (bcd_out updates the cycle after tick).
- Up count: at count==limit the next tick gives 0 and wrap=1. If limit=0, the count stays 0 and wrap pulses every tick.
- Down count: saturates at 0 and never underflows.
- clear in any state loads 0 (dir_q=0) or preset_q (dir_q=1). The FSM goes to IDLE, except from RUN, which stays RUN and restarts from the reloaded value with the prescaler zeroed.
- Priority on the same cycle: reset_btn > clear > preset_load > start_stop > tick.
- warn_led: counter toggles the LED every BLINK_CYCLES while the warning condition holds. It is 0 and the counter is cleared otherwise.
- Reset mid-count aborts immediately; no pulse outputs are asserted on the reset cycle.

Optional Feature:
- Macro: TIMER_LAP_CAPTURE_EN.
- Defined: adds input lap (pulse) and output lap_active.
  - First lap pulse in RUN snapshots the count. bcd_out shows the snapshot while counting continues internally.
  - The second lap pulse releases the display back to the live count.
  - clear, reset, or leaving RUN/PAUSE releases the snapshot.
- Undefined: the lap and lap_active ports are absent; bcd_out is always the live count.

Decomposition:
- Package timer_pkg holds:
  - state enum {IDLE, RUN, PAUSE, EXPIRED};
  - rate_sel encodings;
  - DIGIT_W=4 and BCD_MAX=4'd9;
  - a function computing the prescaler terminal count.
- Sub-module bcd_digit: one decade up/down counter with load, en, dir, carry-in/borrow-in and carry-out/borrow-out. It is instantiated DIGITS times in a generate chain.

Test Plan (CLK_HZ=1000, BASE_HZ=10, DIGITS=3, WARN_LEVEL=5, BLINK_CYCLES=4):
- Up count, rate_sel=00, limit=012, start_stop: tick every 100 cycles; bcd_out steps 000..012. The next tick gives 000 with wrap=1 for one cycle.
- Down count, preset_load 007, start_stop:
  - reaches 000 after 7 ticks;
  - done pulses once, expired=1, running=0;
  - warn_led toggles every 4 cycles from count 005 until expiry.
- rate_sel changed 00->11 mid-run: prescaler zeroes; the next tick arrives exactly 12 cycles later (terminal count 1000/80-1=11).
- Pause/resume: start_stop at count 004, wait 500 cycles (count holds 004), start_stop again; the next tick comes 100 cycles later.
- preset_load of 0x9F3 while stopped gives preset_q=993. preset_load during RUN is ignored. clear and preset_load on the same cycle: the clear path wins.
- reset_btn asserted mid-run at count 050: the next cycle has bcd_out=000, FSM IDLE, and no done/wrap pulse.

Source files
------------

// File: rtl/bcd_updown_timer_pkg.sv
// Shared types and helpers for the BCD up/down timer: run-control states,
// rate encodings, digit constants and prescaler terminal-count arithmetic.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [1:0] RATE_X1 = 2'b00;
  localparam logic [1:0] RATE_X2 = 2'b01;
  localparam logic [1:0] RATE_X4 = 2'b10;
  localparam logic [1:0] RATE_X8 = 2'b11;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic int presc_tc(input int clk_hz, input int base_hz, input logic [1:0] rate);
    return clk_hz / (base_hz << rate) - 1;
  endfunction

  function automatic logic [3:0] clamp_digit(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

  // Binary to packed BCD (up to 8 digits); saturates to all nines on overflow.
  function automatic logic [31:0] bin_to_bcd(input int value, input int digits);
    logic [31:0] r;
    int          v;
    r = '0;
    v = value;
    for (int i = 0; i < 8; i++) begin
      if (i < digits) begin
        r[i*4 +: 4] = 4'(v % 10);
        v           = v / 10;
      end
    end
    if (v > 0) begin
      for (int i = 0; i < 8; i++) begin
        if (i < digits) r[i*4 +: 4] = BCD_MAX;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_updown_timer_digit.sv
// One decade of the BCD count: loadable up/down counter whose carry/borrow
// chain ripples combinationally so a whole multi-digit step completes in one cycle.
module bcd_digit
  import timer_pkg::*;
(
  input  logic               clk_50M,
  input  logic               reset_btn,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               en,
  input  logic               dir,
  input  logic               cin,
  output logic [DIGIT_W-1:0] q,
  output logic               cout
);

  // cin doubles as borrow-in when dir=1; cout as borrow-out.
  assign cout = cin && (dir ? (q == '0) : (q == BCD_MAX));

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (en && cin) begin
      if (dir) q <= (q == '0) ? BCD_MAX : q - 1'b1;
      else     q <= (q == BCD_MAX) ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_updown_timer.sv
// Up/down BCD timer with prescaler, preset/limit registers and run-control FSM.
// Optional lap capture of the displayed count is enabled by TIMER_LAP_CAPTURE_EN.
module bcd_updown_timer
  import timer_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BASE_HZ      = 10,
  parameter int DIGITS       = 3,
  parameter int WARN_LEVEL   = 50,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                      clk_50M,
  input  logic                      reset_btn,
  input  logic                      start_stop,
  input  logic                      clear,
  input  logic                      dir,
  input  logic [1:0]                rate_sel,
  input  logic [DIGIT_W*DIGITS-1:0] preset,
  input  logic                      preset_load,
  input  logic [DIGIT_W*DIGITS-1:0] limit,
`ifdef TIMER_LAP_CAPTURE_EN
  input  logic                      lap,
  output logic                      lap_active,
`endif
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      running,
  output logic                      done,
  output logic                      expired,
  output logic                      wrap,
  output logic                      warn_led,
  output logic                      tick
);

  localparam int CW = DIGIT_W * DIGITS;
  localparam int PW = (CLK_HZ / BASE_HZ > 2) ? $clog2(CLK_HZ / BASE_HZ) : 1;
  localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [PW-1:0] TC_X1      = PW'(presc_tc(CLK_HZ, BASE_HZ, RATE_X1));
  localparam logic [PW-1:0] TC_X2      = PW'(presc_tc(CLK_HZ, BASE_HZ, RATE_X2));
  localparam logic [PW-1:0] TC_X4      = PW'(presc_tc(CLK_HZ, BASE_HZ, RATE_X4));
  localparam logic [PW-1:0] TC_X8      = PW'(presc_tc(CLK_HZ, BASE_HZ, RATE_X8));
  localparam logic [CW-1:0] WARN_BCD   = CW'(bin_to_bcd(WARN_LEVEL, DIGITS));
  localparam logic [CW-1:0] ONE        = CW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   count, preset_q, preset_clamped, load_val;
  logic            dir_q;
  logic [1:0]      rate_q;
  logic [PW-1:0]   presc, tc;
  logic            rate_chg, cnt_load, cnt_en, done_nx, wrap_nx, warn_cond;
  logic [BW-1:0]   blink_cnt;
  logic [DIGITS:0] carry;

  always_comb begin
    tc = TC_X1;
    case (rate_sel)
      RATE_X1: tc = TC_X1;
      RATE_X2: tc = TC_X2;
      RATE_X4: tc = TC_X4;
      RATE_X8: tc = TC_X8;
      default: tc = TC_X1;
    endcase
  end

  always_comb begin
    preset_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      preset_clamped[i*4 +: 4] = clamp_digit(preset[i*4 +: 4]);
    end
  end

  // A tick is swallowed by any higher-priority control event on the same cycle.
  assign rate_chg = (rate_sel != rate_q);
  assign tick     = (state == RUN) && (presc == tc) && !rate_chg && !clear && !start_stop;

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    load_val = '0;
    cnt_en   = 1'b0;
    done_nx  = 1'b0;
    wrap_nx  = 1'b0;
    if (clear) begin
      cnt_load = 1'b1;
      load_val = (dir_q || state == EXPIRED) ? preset_q : '0;
      state_nx = (state == RUN) ? RUN : IDLE;
    end else if (preset_load && state != RUN) begin
      // In IDLE a down-counter shows the new preset at once so start is not blocked.
      if (state == IDLE && dir_q) begin
        cnt_load = 1'b1;
        load_val = preset_clamped;
      end
    end else if (start_stop) begin
      case (state)
        IDLE:    if (!(dir_q && count == '0)) state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        EXPIRED: begin
          state_nx = IDLE;
          cnt_load = 1'b1;
          load_val = preset_q;
        end
        default: state_nx = IDLE;
      endcase
    end else if (tick) begin
      if (!dir_q) begin
        if (count == limit) begin
          cnt_load = 1'b1;
          wrap_nx  = 1'b1;
        end else begin
          cnt_en  = 1'b1;
          wrap_nx = carry[DIGITS];
        end
      end else if (count != '0) begin
        cnt_en = 1'b1;
        if (count == ONE) begin
          done_nx  = 1'b1;
          state_nx = EXPIRED;
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      state    <= IDLE;
      preset_q <= '0;
      dir_q    <= 1'b0;
      rate_q   <= RATE_X1;
      presc    <= '0;
      done     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state  <= state_nx;
      done   <= done_nx;
      wrap   <= wrap_nx;
      rate_q <= rate_sel;
      if (state != RUN) dir_q <= dir;
      if (preset_load && !clear && state != RUN) preset_q <= preset_clamped;
      if (state != RUN || state_nx != RUN || rate_chg || clear || tick) presc <= '0;
      else presc <= presc + 1'b1;
    end
  end

  assign carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_50M   (clk_50M),
      .reset_btn (reset_btn),
      .load      (cnt_load),
      .load_val  (load_val[g*4 +: 4]),
      .en        (cnt_en),
      .dir       (dir_q),
      .cin       (carry[g]),
      .q         (count[g*4 +: 4]),
      .cout      (carry[g+1])
    );
  end

  // Packed BCD orders the same as its binary value, so compare digits directly.
  assign warn_cond = dir_q && (state == RUN) && (count <= WARN_BCD);

  always_ff @(posedge clk_50M) begin
    if (reset_btn || !warn_cond) begin
      blink_cnt <= '0;
      warn_led  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      warn_led  <= ~warn_led;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

`ifdef TIMER_LAP_CAPTURE_EN
  logic [CW-1:0] lap_q;
  logic          lap_hold;

  always_ff @(posedge clk_50M) begin
    if (reset_btn) begin
      lap_hold <= 1'b0;
      lap_q    <= '0;
    end else if (clear || !(state_nx == RUN || state_nx == PAUSE)) begin
      lap_hold <= 1'b0;
    end else if (lap) begin
      if (lap_hold) begin
        lap_hold <= 1'b0;
      end else if (state == RUN) begin
        lap_hold <= 1'b1;
        lap_q    <= count;
      end
    end
  end

  assign bcd_out    = lap_hold ? lap_q : count;
  assign lap_active = lap_hold;
`else
  assign bcd_out = count;
`endif

endmodule
